sobel_edge_detector: RTL and testbench

Downstream consumer of the SPI pixel-window stage. Takes each valid 3x3 window of 4-bit grayscale pixels plus its (x,y) coordinate and computes the Sobel gradient magnitude |Gx|+|Gy| in a 3-stage pipeline. It then thresholds the result into a binary edge bit and keeps a per-frame edge count. Outputs feed the frame-buffer/VGA write stage.

---
 rtl/edge_pkg.sv | 34 +++
 rtl/sobel_kernel.sv | 93 +++++++++
 rtl/sobel_edge_detector.sv | 118 +++++++++++
 tb/tb_sobel_edge_detector.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the Sobel edge stage and its upstream window source.
// Latency: n/a (types, constants and combinational helpers only).
// Backpressure: n/a.
package edge_pkg;

    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;
    localparam int PIX_W          = 4;
    localparam int MAG_W          = 7;
    localparam int CNT_W          = 19;
    localparam int SUM_W          = 6;   // weighted 1-2-1 sum of three 4-bit pixels, max 60
    localparam int X_W            = 10;
    localparam int Y_W            = 9;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [MAG_W-1:0] mag_t;
    typedef logic [SUM_W-1:0] sum_t;

    // Indexed [row][col]; row 0 is the top row, col 0 the leftmost column.
    typedef pixel_t [2:0][2:0] window_t;

    // Weighted sum a + 2b + c, the 1-2-1 smoothing tap of the Sobel operator.
    function automatic sum_t wsum(input pixel_t a, input pixel_t b, input pixel_t c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Magnitude of a gradient in -60..60; always fits back into SUM_W bits.
    function automatic sum_t abs_grad(input logic signed [SUM_W:0] g);
        logic signed [SUM_W:0] neg;
        neg = -g;
        return g[SUM_W] ? sum_t'(neg) : sum_t'(g);
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Sobel stages 1-2: column/row weighted sums, then |Gx| and |Gy|, with valid and x/y carried alongside.
// Latency: 2 cycles, fully pipelined, one window per cycle.
// Backpressure: none; advances every cycle, bubbles travel as valid=0.
module sobel_kernel
    import edge_pkg::*;
(
    input  logic           mainClk,
    input  logic           nreset,
    input  window_t        win_i,
    input  logic           vld_i,
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    output logic           vld_o,
    output sum_t           abs_gx_o,
    output sum_t           abs_gy_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o
);

    logic           s1_vld_q;
    sum_t           l_q, r_q, t_q, b_q;
    sum_t           l_d, r_d, t_d, b_d;
    logic [X_W-1:0] s1_x_q;
    logic [Y_W-1:0] s1_y_q;

    logic                  s2_vld_q;
    sum_t                  agx_q, agy_q;
    sum_t                  agx_d, agy_d;
    logic signed [SUM_W:0] gx_d, gy_d;
    logic [X_W-1:0]        s2_x_q;
    logic [Y_W-1:0]        s2_y_q;

    // Stage 1 sums: left/right columns feed Gx, top/bottom rows feed Gy.
    always_comb begin
        l_d = wsum(win_i[0][0], win_i[1][0], win_i[2][0]);
        r_d = wsum(win_i[0][2], win_i[1][2], win_i[2][2]);
        t_d = wsum(win_i[0][0], win_i[0][1], win_i[0][2]);
        b_d = wsum(win_i[2][0], win_i[2][1], win_i[2][2]);
    end

    // Stage 1 register: sums plus valid and coordinates.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            s1_vld_q <= 1'b0;
            l_q      <= '0;
            r_q      <= '0;
            t_q      <= '0;
            b_q      <= '0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
        end else begin
            s1_vld_q <= vld_i;
            l_q      <= l_d;
            r_q      <= r_d;
            t_q      <= t_d;
            b_q      <= b_d;
            s1_x_q   <= x_i;
            s1_y_q   <= y_i;
        end
    end

    // Stage 2 gradients as signed differences, reduced to magnitudes.
    always_comb begin
        gx_d  = $signed({1'b0, r_q}) - $signed({1'b0, l_q});
        gy_d  = $signed({1'b0, b_q}) - $signed({1'b0, t_q});
        agx_d = abs_grad(gx_d);
        agy_d = abs_grad(gy_d);
    end

    // Stage 2 register: gradient magnitudes plus valid and coordinates.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            s2_vld_q <= 1'b0;
            agx_q    <= '0;
            agy_q    <= '0;
            s2_x_q   <= '0;
            s2_y_q   <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            agx_q    <= agx_d;
            agy_q    <= agy_d;
            s2_x_q   <= s1_x_q;
            s2_y_q   <= s1_y_q;
        end
    end

    assign vld_o    = s2_vld_q;
    assign abs_gx_o = agx_q;
    assign abs_gy_o = agy_q;
    assign x_o      = s2_x_q;
    assign y_o      = s2_y_q;

endmodule

// File: rtl/sobel_edge_detector.sv
// Sobel edge detector: |Gx|+|Gy| per 3x3 window, border suppression, threshold, per-frame edge count.
// Latency: 3 cycles from window capture to registered result; one result per cycle.
// Backpressure: none; outputs hold their last value while edgeValid is low.
module sobel_edge_detector
    import edge_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic             mainClk,
    input  logic             nreset,
    input  window_t          pixelData,
    input  logic             pixelDataValid,
    input  logic [X_W-1:0]   spiXVal,
    input  logic [Y_W-1:0]   spiYVal,
    input  mag_t             threshold,
    output logic             edgeValid,
    output mag_t             edgeMag,
    output logic             edgePixel,
    output logic [X_W-1:0]   edgeXVal,
    output logic [Y_W-1:0]   edgeYVal,
    output logic             frameDone,
    output logic [CNT_W-1:0] edgeCount
);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

    logic           k_vld;
    sum_t           k_agx, k_agy;
    logic [X_W-1:0] k_x;
    logic [Y_W-1:0] k_y;

    sobel_kernel u_kernel (
        .mainClk  (mainClk),
        .nreset   (nreset),
        .win_i    (pixelData),
        .vld_i    (pixelDataValid),
        .x_i      (spiXVal),
        .y_i      (spiYVal),
        .vld_o    (k_vld),
        .abs_gx_o (k_agx),
        .abs_gy_o (k_agy),
        .x_o      (k_x),
        .y_o      (k_y)
    );

    logic             vld_q, pix_q, done_q;
    mag_t             mag_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [CNT_W-1:0] cnt_q, run_q;

    logic             border_d, first_d, last_d, pix_d, done_d;
    mag_t             mag_d;
    logic [CNT_W-1:0] cnt_d, run_d;

    // Stage 3 combinational: magnitude with border/out-of-range suppression and threshold.
    // The >= comparisons against the last index also catch coordinates beyond the image.
    always_comb begin
        border_d = (k_x == '0) || (k_y == '0) || (k_x >= X_LAST) || (k_y >= Y_LAST);
        mag_d    = border_d ? '0 : ({1'b0, k_agx} + {1'b0, k_agy});
        pix_d    = (mag_d != '0) && (mag_d >= threshold);
        first_d  = (k_x == '0) && (k_y == '0);
        last_d   = (k_x == X_LAST) && (k_y == Y_LAST);
        done_d   = k_vld && last_d;
    end

    // Frame counter: (0,0) restarts the run, the last pixel publishes it; missing last pixel leaves edgeCount alone.
    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (k_vld) begin
            if (first_d) begin
                run_d = CNT_W'(pix_d);
            end else if (last_d) begin
                cnt_d = run_q + CNT_W'(pix_d);
                run_d = '0;
            end else begin
                run_d = run_q + CNT_W'(pix_d);
            end
        end
    end

    // Stage 3 output register; result fields only load on a valid result so they hold across bubbles.
    always_ff @(posedge mainClk or negedge nreset) begin
        if (!nreset) begin
            vld_q  <= 1'b0;
            mag_q  <= '0;
            pix_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            run_q  <= '0;
        end else begin
            vld_q  <= k_vld;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            if (k_vld) begin
                mag_q <= mag_d;
                pix_q <= pix_d;
                x_q   <= k_x;
                y_q   <= k_y;
            end
        end
    end

    assign edgeValid = vld_q;
    assign edgeMag   = mag_q;
    assign edgePixel = pix_q;
    assign edgeXVal  = x_q;
    assign edgeYVal  = y_q;
    assign frameDone = done_q;
    assign edgeCount = cnt_q;

endmodule

// File: tb/tb_sobel_edge_detector.sv
// Bench for sobel_edge_detector: full-size instance plus a 4x3 mini-frame instance on shared inputs.
// Latency: outputs compared every cycle against a reference model, 3-cycle delay.
// Backpressure: none.
module tb_sobel_edge_detector;
    import edge_pkg::*;

    logic             mainClk = 1'b0;
    logic             nreset;
    window_t          pix;
    logic             pv;
    logic [X_W-1:0]   sx;
    logic [Y_W-1:0]   sy;
    mag_t             thr;

    logic             a_vld, a_pix, a_done;
    mag_t             a_mag;
    logic [X_W-1:0]   a_x;
    logic [Y_W-1:0]   a_y;
    logic [CNT_W-1:0] a_cnt;

    logic             b_vld, b_pix, b_done;
    mag_t             b_mag;
    logic [X_W-1:0]   b_x;
    logic [Y_W-1:0]   b_y;
    logic [CNT_W-1:0] b_cnt;

    always #5 mainClk = ~mainClk;

    sobel_edge_detector #(.IMG_WIDTH(640), .IMG_HEIGHT(480)) dut_a (
        .mainClk(mainClk), .nreset(nreset), .pixelData(pix), .pixelDataValid(pv),
        .spiXVal(sx), .spiYVal(sy), .threshold(thr),
        .edgeValid(a_vld), .edgeMag(a_mag), .edgePixel(a_pix), .edgeXVal(a_x),
        .edgeYVal(a_y), .frameDone(a_done), .edgeCount(a_cnt)
    );

    sobel_edge_detector #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) dut_b (
        .mainClk(mainClk), .nreset(nreset), .pixelData(pix), .pixelDataValid(pv),
        .spiXVal(sx), .spiYVal(sy), .threshold(thr),
        .edgeValid(b_vld), .edgeMag(b_mag), .edgePixel(b_pix), .edgeXVal(b_x),
        .edgeYVal(b_y), .frameDone(b_done), .edgeCount(b_cnt)
    );

    int total = 0;
    int bad   = 0;
    int done_seen_b = 0;

    // Reference model: two-slot input delay, then the Sobel result computed from the window directly.
    logic    m_s1v, m_s2v;
    window_t m_s1w, m_s2w;
    int      m_s1x, m_s1y, m_s2x, m_s2y;
    int      e_vld[2], e_mag[2], e_pix[2], e_x[2], e_y[2], e_done[2], e_cnt[2], e_run[2];
    int      img_w[2] = '{640, 4};
    int      img_h[2] = '{480, 3};

    function automatic int ref_mag(input window_t w, input int x, input int y, input int wd, input int ht);
        int kx[3][3];
        int ky[3][3];
        int gx, gy;
        kx = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
        ky = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
        if (x <= 0 || y <= 0 || x >= wd - 1 || y >= ht - 1) return 0;
        gx = 0;
        gy = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                gx += kx[r][c] * int'(w[r][c]);
                gy += ky[r][c] * int'(w[r][c]);
            end
        return ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    endfunction

    task automatic model_reset();
        m_s1v = 1'b0; m_s2v = 1'b0;
        m_s1w = '0;   m_s2w = '0;
        m_s1x = 0; m_s1y = 0; m_s2x = 0; m_s2y = 0;
        for (int i = 0; i < 2; i++) begin
            e_vld[i] = 0; e_mag[i] = 0; e_pix[i] = 0; e_x[i] = 0;
            e_y[i] = 0; e_done[i] = 0; e_cnt[i] = 0; e_run[i] = 0;
        end
    endtask

    task automatic model_edge();
        int mag, p;
        bit last;
        if (!nreset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            e_vld[i]  = int'(m_s2v);
            e_done[i] = 0;
            if (m_s2v) begin
                mag  = ref_mag(m_s2w, m_s2x, m_s2y, img_w[i], img_h[i]);
                p    = (mag > 0 && mag >= int'(thr)) ? 1 : 0;
                last = (m_s2x == img_w[i] - 1) && (m_s2y == img_h[i] - 1);
                e_mag[i] = mag; e_pix[i] = p; e_x[i] = m_s2x; e_y[i] = m_s2y;
                if (m_s2x == 0 && m_s2y == 0) e_run[i] = p;
                else if (last) begin
                    e_cnt[i]  = e_run[i] + p;
                    e_run[i]  = 0;
                    e_done[i] = 1;
                end else e_run[i] += p;
            end
        end
        m_s2v = m_s1v; m_s2w = m_s1w; m_s2x = m_s1x; m_s2y = m_s1y;
        m_s1v = pv;    m_s1w = pix;   m_s1x = int'(sx); m_s1y = int'(sy);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a.edgeValid", a_vld, e_vld[0]);   chk("b.edgeValid", b_vld, e_vld[1]);
        chk("a.edgeMag",   a_mag, e_mag[0]);   chk("b.edgeMag",   b_mag, e_mag[1]);
        chk("a.edgePixel", a_pix, e_pix[0]);   chk("b.edgePixel", b_pix, e_pix[1]);
        chk("a.edgeXVal",  a_x,   e_x[0]);     chk("b.edgeXVal",  b_x,   e_x[1]);
        chk("a.edgeYVal",  a_y,   e_y[0]);     chk("b.edgeYVal",  b_y,   e_y[1]);
        chk("a.frameDone", a_done, e_done[0]); chk("b.frameDone", b_done, e_done[1]);
        chk("a.edgeCount", a_cnt, e_cnt[0]);   chk("b.edgeCount", b_cnt, e_cnt[1]);
    endtask

    task automatic cyc();
        @(posedge mainClk);
        model_edge();
        #1;
        check_all();
        if (b_done === 1'b1) done_seen_b++;
    endtask

    task automatic send(input window_t w, input int x, input int y);
        pix = w; sx = X_W'(x); sy = Y_W'(y); pv = 1'b1;
        cyc();
        pv = 1'b0;
    endtask

    function automatic window_t mk_fill(input int v);
        window_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) w[r][c] = PIX_W'(v);
        return w;
    endfunction

    function automatic window_t mk_vert();
        window_t w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            w[r][1] = 4'd15;
            w[r][2] = 4'd15;
        end
        return w;
    endfunction

    function automatic window_t mk_corner();
        window_t w;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            w[0][i] = 4'd15;
            w[i][2] = 4'd15;
        end
        return w;
    endfunction

    function automatic window_t mk_rand();
        window_t w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) w[r][c] = PIX_W'($urandom_range(0, 15));
        return w;
    endfunction

    function automatic int pick_x();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 1;
            2: return 638;
            3: return 639;
            4: return 640;
            5: return 1023;
            default: return int'($urandom_range(0, 700));
        endcase
    endfunction

    function automatic int pick_y();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 1;
            2: return 478;
            3: return 479;
            4: return 480;
            5: return 511;
            default: return int'($urandom_range(0, 520));
        endcase
    endfunction

    task automatic mini_frame(input window_t w);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) send(w, x, y);
        cyc();
        cyc();
    endtask

    initial begin
        nreset = 1'b0; pv = 1'b0; pix = '0; sx = '0; sy = '0; thr = '0;
        model_reset();
        #3;
        check_all();
        cyc();
        cyc();
        nreset = 1'b1;
        cyc();

        // Flat window gives no gradient.
        thr = 7'd10;
        send(mk_fill(5), 100, 100);
        cyc(); cyc();
        chk("flat_vld", a_vld, 1); chk("flat_mag", a_mag, 0); chk("flat_pix", a_pix, 0);
        chk("flat_x", a_x, 100);   chk("flat_y", a_y, 100);

        // Vertical edge, interior then on the left border.
        thr = 7'd40;
        send(mk_vert(), 50, 60);
        cyc(); cyc();
        chk("vert_mag", a_mag, 60); chk("vert_pix", a_pix, 1);
        send(mk_vert(), 0, 60);
        cyc(); cyc();
        chk("vert_border_mag", a_mag, 0); chk("vert_border_pix", a_pix, 0);

        // Corner window at the threshold boundary.
        thr = 7'd90;
        send(mk_corner(), 10, 10);
        cyc(); cyc();
        chk("corner_mag", a_mag, 90); chk("corner_pix_t90", a_pix, 1);
        thr = 7'd91;
        send(mk_corner(), 10, 10);
        cyc(); cyc();
        chk("corner_pix_t91", a_pix, 0);

        // Zero threshold: a flat interior window must still not count as an edge.
        thr = 7'd0;
        send(mk_fill(9), 20, 20);
        cyc(); cyc();
        chk("thr0_flat_pix", a_pix, 0);

        // Five back-to-back windows then a gap.
        thr = 7'd40;
        for (int i = 0; i < 5; i++) send(mk_rand(), 200 + i, 100 + i);
        cyc(); cyc();
        chk("burst_last_x", a_x, 204); chk("burst_last_vld", a_vld, 1);
        cyc();
        chk("gap1_vld", a_vld, 0);
        cyc();
        chk("gap2_vld", a_vld, 0);

        // Mini-frames: vertical edges, then flat, then vertical again.
        done_seen_b = 0;
        mini_frame(mk_vert());
        chk("mini_vert_cnt", b_cnt, 2); chk("mini_vert_done", done_seen_b, 1);
        done_seen_b = 0;
        mini_frame(mk_fill(5));
        chk("mini_flat_cnt", b_cnt, 0); chk("mini_flat_done", done_seen_b, 1);
        mini_frame(mk_vert());
        chk("mini_vert2_cnt", b_cnt, 2);

        // Reset with three windows in flight, including the frame's last pixel.
        send(mk_vert(), 1, 2);
        send(mk_vert(), 2, 2);
        pix = mk_vert(); sx = 10'd3; sy = 9'd2; pv = 1'b1;
        #2;
        nreset = 1'b0;
        model_reset();
        #1;
        check_all();
        pv = 1'b0;
        done_seen_b = 0;
        cyc(); cyc();
        nreset = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("rst_vld", b_vld, 0); chk("rst_cnt", b_cnt, 0);
        chk("rst_done", done_seen_b, 0); chk("rst_a_cnt", a_cnt, 0);

        // Random windows, coordinates near borders, changing thresholds.
        for (int n = 0; n < 400; n++) begin
            if (n % 23 == 0) thr = mag_t'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) send(mk_rand(), pick_x(), pick_y());
            else cyc();
        end

        // Random mini-frames with occasional dropped pixels and gaps.
        for (int f = 0; f < 8; f++) begin
            thr = mag_t'($urandom_range(0, 80));
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 4; x++) begin
                    if ($urandom_range(0, 9) != 0) send(mk_rand(), x, y);
                    if ($urandom_range(0, 3) == 0) cyc();
                end
        end
        for (int i = 0; i < 4; i++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
